// File: rtl/chunk_adder_seq.sv
// Sequential wide adder: adds N = WIDTH*CHUNKS bit operands one WIDTH-bit chunk per clock.
// Optional signed-overflow output enabled by defining CHUNK_ADDER_OVF_EN.

module Compadder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum,
    output logic [WIDTH:0]   tum
);

    // Compound adder: sum is a+b, tum is a+b+1, both with carry-out in the top bit.
    assign sum = {1'b0, a} + {1'b0, b};
    assign tum = sum + (WIDTH + 1)'(1);

endmodule

module chunk_adder_seq #(
    parameter int WIDTH  = 4,
    parameter int CHUNKS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [WIDTH*CHUNKS-1:0]   a,
    input  logic [WIDTH*CHUNKS-1:0]   b,
    input  logic                      cin,
    output logic                      busy,
    output logic                      done,
    output logic [WIDTH*CHUNKS-1:0]   result,
    output logic                      cout
`ifdef CHUNK_ADDER_OVF_EN
    ,
    output logic                      ovf
`endif
);

    localparam int N     = WIDTH * CHUNKS;
    localparam int CNT_W = $clog2(CHUNKS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [N-1:0]     a_sh;
    logic [N-1:0]     b_sh;
    logic             carry;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   tum;
    logic [WIDTH:0]   s;

    // The low chunk of each shift register is always the chunk being processed.
    Compadder #(.WIDTH(WIDTH)) u_comp (
        .a   (a_sh[WIDTH-1:0]),
        .b   (b_sh[WIDTH-1:0]),
        .sum (sum),
        .tum (tum)
    );

    assign s = carry ? tum : sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            count  <= '0;
            carry  <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
`ifdef CHUNK_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    result[32'(count)*WIDTH +: WIDTH] <= s[WIDTH-1:0];
                    carry <= s[WIDTH];
                    a_sh  <= a_sh >> WIDTH;
                    b_sh  <= b_sh >> WIDTH;
                    if (count == LAST) begin
                        cout  <= s[WIDTH];
`ifdef CHUNK_ADDER_OVF_EN
                        // On the last chunk the shift registers hold the operand sign bits.
                        ovf   <= (a_sh[WIDTH-1] == b_sh[WIDTH-1]) &&
                                 (s[WIDTH-1] != a_sh[WIDTH-1]);
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chunk_adder_seq.sv
// Self-checking bench for chunk_adder_seq: transaction-level model plus directed and random stimulus.
// Also sweeps a WIDTH=3, CHUNKS=2 instance exhaustively; CHUNK_ADDER_OVF_EN adds the ovf checks.

module tb_chunk_adder_seq;

    localparam int W  = 4;
    localparam int C  = 4;
    localparam int N  = W * C;
    localparam int SW = 3;
    localparam int SC = 2;
    localparam int SN = SW * SC;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          cin;
    logic          busy;
    logic          done;
    logic [N-1:0]  result;
    logic          cout;
`ifdef CHUNK_ADDER_OVF_EN
    logic          ovf;
    logic          s_ovf;
`endif

    logic          s_reset;
    logic          s_start;
    logic [SN-1:0] s_a;
    logic [SN-1:0] s_b;
    logic          s_cin;
    logic          s_busy;
    logic          s_done;
    logic [SN-1:0] s_result;
    logic          s_cout;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    always #5 clk = ~clk;

    chunk_adder_seq #(.WIDTH(W), .CHUNKS(C)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
`ifdef CHUNK_ADDER_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    chunk_adder_seq #(.WIDTH(SW), .CHUNKS(SC)) dut_small (
        .clk    (clk),
        .reset  (s_reset),
        .start  (s_start),
        .a      (s_a),
        .b      (s_b),
        .cin    (s_cin),
        .busy   (s_busy),
        .done   (s_done),
        .result (s_result),
        .cout   (s_cout)
`ifdef CHUNK_ADDER_OVF_EN
        ,
        .ovf    (s_ovf)
`endif
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [N-1:0] ia, input logic [N-1:0] ib,
                                 input logic icin, input logic istart);
        a     = ia;
        b     = ib;
        cin   = icin;
        start = istart;
    endtask

    // Returns the number of cycles waited; an expired budget is reported as a failure.
    task automatic waitDone(input int budget, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!done && cyc < budget);
        if (!done) checkOutput("done_timeout", 64'd0, 64'd1);
    endtask

    // Transaction model: an accepted add is busy for C cycles, then shows its exact sum with done.
    bit           m_busy  = 1'b0;
    bit           m_done  = 1'b0;
    bit           m_valid = 1'b0;
    int           m_left  = 0;
    logic [N:0]   m_pend  = '0;
    bit           m_pend_ovf = 1'b0;
    logic [N-1:0] m_res   = '0;
    bit           m_cout  = 1'b0;
    bit           m_ovf   = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_left  = 0;
            m_res   = '0;
            m_cout  = 1'b0;
            m_ovf   = 1'b0;
            m_valid = 1'b1;
        end else if (!m_busy && start) begin
            m_pend     = {1'b0, a} + {1'b0, b} + (N + 1)'(cin);
            m_pend_ovf = (a[N-1] == b[N-1]) && (m_pend[N-1] != a[N-1]);
            m_busy     = 1'b1;
            m_done     = 1'b0;
            m_left     = C;
            m_valid    = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy  = 1'b0;
                m_done  = 1'b1;
                m_res   = m_pend[N-1:0];
                m_cout  = m_pend[N];
                m_ovf   = m_pend_ovf;
                m_valid = 1'b1;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("busy", 64'(busy), 64'(m_busy));
            checkOutput("done", 64'(done), 64'(m_done));
            if (m_valid) begin
                checkOutput("result", 64'(result), 64'(m_res));
                checkOutput("cout", 64'(cout), 64'(m_cout));
`ifdef CHUNK_ADDER_OVF_EN
                checkOutput("ovf", 64'(ovf), 64'(m_ovf));
`endif
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int busy_cnt;
        int done_cnt;

        reset   = 1'b1;
        s_reset = 1'b1;
        s_start = 1'b0;
        s_a     = '0;
        s_b     = '0;
        s_cin   = 1'b0;
        applyStimulus('0, '0, 1'b0, 1'b0);
        repeat (2) tick();
        chk_en = 1'b1;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_result", 64'(result), 64'd0);
        checkOutput("reset_cout", 64'(cout), 64'd0);
        reset   = 1'b0;
        s_reset = 1'b0;
        repeat (2) tick();

        // All-ones plus one: full carry ripple, latency of C cycles after accept.
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        tick();
        start = 1'b0;
        waitDone(10, cyc);
        checkOutput("ripple_latency", 64'(cyc), 64'(C));
        checkOutput("ripple_result", 64'(result), 64'h0000);
        checkOutput("ripple_cout", 64'(cout), 64'd1);
        tick();

        applyStimulus(16'h1234, 16'h4321, 1'b1, 1'b1);
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            start = 1'b0;
            busy_cnt += int'(busy);
            done_cnt += int'(done);
        end
        checkOutput("cin_result", 64'(result), 64'h5556);
        checkOutput("cin_cout", 64'(cout), 64'd0);
        checkOutput("cin_busy_cycles", 64'(busy_cnt), 64'd4);
        checkOutput("cin_done_cycles", 64'(done_cnt), 64'd1);

        // A start pulse while busy must be dropped entirely.
        applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b1);
        tick();
        start = 1'b0;
        repeat (2) tick();
        applyStimulus(16'hAAAA, 16'h5555, 1'b1, 1'b1);
        tick();
        applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            done_cnt += int'(done);
            tick();
        end
        checkOutput("ignore_done_count", 64'(done_cnt), 64'd1);
        checkOutput("ignore_result", 64'(result), 64'h3333);
        checkOutput("ignore_cout", 64'(cout), 64'd0);

        // Reset sampled on the edge that would process chunk 1 aborts the add.
        applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b1);
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_result", 64'(result), 64'd0);
        checkOutput("abort_cout", 64'(cout), 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            done_cnt += int'(done);
        end
        checkOutput("abort_no_done", 64'(done_cnt), 64'd0);

        // Reset and start together: reset wins.
        applyStimulus(16'h0F0F, 16'h0101, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        checkOutput("reset_start_busy", 64'(busy), 64'd0);
        tick();

        // Start held high: back-to-back operation from the DONE cycle.
        applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b1);
        tick();
        waitDone(10, cyc);
        checkOutput("hold1_result", 64'(result), 64'h0100);
        checkOutput("hold1_cout", 64'(cout), 64'd0);
        applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b1);
        tick();
        waitDone(10, cyc);
        checkOutput("hold2_latency", 64'(cyc), 64'(C));
        checkOutput("hold2_result", 64'(result), 64'h0000);
        checkOutput("hold2_cout", 64'(cout), 64'd1);
        start = 1'b0;
        tick();

`ifdef CHUNK_ADDER_OVF_EN
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        tick();
        start = 1'b0;
        waitDone(10, cyc);
        checkOutput("ovf_pos", 64'(ovf), 64'd1);
        tick();
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        tick();
        start = 1'b0;
        waitDone(10, cyc);
        checkOutput("ovf_none", 64'(ovf), 64'd0);
        tick();
`endif

        // Random traffic with occasional resets; the model checks every cycle.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(N'($urandom), N'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0));
            reset = ($urandom_range(0, 59) == 0);
            tick();
        end
        reset = 1'b0;
        start = 1'b0;
        repeat (8) tick();

        // Exhaustive sweep of the small configuration with start held high.
        for (int sa = 0; sa < 64; sa++) begin
            for (int sb = 0; sb < 64; sb++) begin
                for (int sc = 0; sc < 2; sc++) begin
                    s_a     = SN'(sa);
                    s_b     = SN'(sb);
                    s_cin   = 1'(sc);
                    s_start = 1'b1;
                    tick();
                    cyc = 0;
                    do begin
                        tick();
                        cyc++;
                    end while (!s_done && cyc < 6);
                    if (!s_done) checkOutput("small_done_timeout", 64'd0, 64'd1);
                    checkOutput("small_sum", 64'({s_cout, s_result}), 64'(sa + sb + sc));
                end
            end
        end
        s_start = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
